// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive controller: register map,
// STAT/CTRL bit positions and bus FSM state encodings.
package uart_rx_ctrl_pkg;

    // Register addresses
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_STAT = 1'b1;

    // STAT read bit positions
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_IRQ_EN    = 4;
    localparam int STAT_RX_ACTIVE = 5;
    localparam int STAT_COUNT_LSB = 8;

    // CTRL write bit positions
    localparam int CTRL_CLR_OVR = 2;
    localparam int CTRL_CLR_TO  = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int CTRL_FLUSH   = 7;

    // Bus FSM states
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACK  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO: push/pop/flush with full/empty/count.
// A pop on empty is ignored; a push on full only lands when a pop frees a slot
// in the same cycle. Flush overrides both.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int BITS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [BITS-1:0]          wdata,
    output logic [BITS-1:0]          rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures received bytes into a FIFO and exposes
// DATA / STAT / CTRL registers on a single-cycle-ack Wishbone slave.
// Interrupt on watermark, idle timeout or overrun.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int BITS         = 8,
    parameter int DEPTH        = 8,
    parameter int WATERMARK    = 4,
    parameter int TIMEOUT_CLKS = 1040
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_done,
    input  logic            rx_active,
    input  logic [BITS-1:0] rx_data,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic            i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    output logic [31:0]     o_wb_rdt,
    output logic            o_wb_ack,
    output logic            o_irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] WM      = CW'(WATERMARK);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic            state;
    logic            rx_done_q;
    logic            push, req, pop_req, pop_eff, ctrl_wr, flush, ovf;
    logic            overrun, timeout, irq_en;
    logic [TW-1:0]   to_cnt;
    logic [BITS-1:0] head;
    logic            full, empty;
    logic [CW-1:0]   count;
    logic [31:0]     stat, rd_next;
    logic            unused_ok;

    assign unused_ok = ^{i_wb_dat[31:8], i_wb_dat[6:5], i_wb_dat[1:0]};

    assign push    = rx_done & ~rx_done_q;
    assign req     = (state == ST_IDLE) & i_wb_cyc & i_wb_stb;
    assign pop_req = req & ~i_wb_we & (i_wb_adr == ADR_DATA);
    assign pop_eff = pop_req & ~empty;
    assign ctrl_wr = req & i_wb_we & (i_wb_adr == ADR_STAT);
    assign flush   = ctrl_wr & i_wb_dat[CTRL_FLUSH];
    // A byte is lost only when it cannot land: full, no slot freed, no flush
    assign ovf     = push & full & ~pop_eff & ~flush;
    assign o_wb_ack = (state == ST_ACK);

    uart_rx_fifo #(.DEPTH(DEPTH), .BITS(BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop_req),
        .flush (flush),
        .wdata (rx_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Status word and read-data selection for the current request
    always_comb begin
        stat = '0;
        stat[STAT_NOT_EMPTY] = ~empty;
        stat[STAT_FULL]      = full;
        stat[STAT_OVERRUN]   = overrun;
        stat[STAT_TIMEOUT]   = timeout;
        stat[STAT_IRQ_EN]    = irq_en;
        stat[STAT_RX_ACTIVE] = rx_active;
        stat[STAT_COUNT_LSB +: CW] = count;
        rd_next = '0;
        if (req && !i_wb_we) begin
            if (i_wb_adr == ADR_STAT) rd_next = stat;
            else if (!empty)          rd_next = 32'(head);
        end
    end

    // Bus FSM, read data register and rx_done edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            o_wb_rdt  <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            o_wb_rdt  <= rd_next;
            state     <= req ? ST_ACK : ST_IDLE;
        end
    end

    // Control bits and sticky flags; a set in the same cycle beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en  <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= i_wb_dat[CTRL_IRQ_EN];
            if (ctrl_wr && i_wb_dat[CTRL_CLR_OVR]) overrun <= 1'b0;
            if (ovf) overrun <= 1'b1;
            if (empty || (ctrl_wr && i_wb_dat[CTRL_CLR_TO])) timeout <= 1'b0;
            if (!empty && !rx_active && !(push || pop_eff || flush) && to_cnt == TO_LAST)
                timeout <= 1'b1;
        end
    end

    // Idle timer: counts while data waits and the line is quiet, holds at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (push || pop_eff || flush)
            to_cnt <= '0;
        else if (!empty && !rx_active && to_cnt != TO_LAST)
            to_cnt <= to_cnt + 1'b1;
    end

    // Registered interrupt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_irq <= 1'b0;
        else        o_irq <= irq_en & ((count >= WM) | timeout | overrun);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int WM    = 4;
    localparam int TO    = 1040;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rx_done = 1'b0, rx_active = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
    logic [31:0] dat = '0;
    logic [31:0] rdt;
    logic        ack, irq;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.BITS(8), .DEPTH(DEPTH), .WATERMARK(WM), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_active(rx_active), .rx_data(rx_data),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(dat),
        .o_wb_rdt(rdt), .o_wb_ack(ack), .o_irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];
    logic        m_ovr = 0, m_to = 0, m_en = 0, m_ack = 0, m_irq = 0, m_rxd_q = 0;
    logic [31:0] m_rdt = '0;
    int          m_idle = 0;

    function automatic logic [31:0] m_stat();
        int sz = mq.size();
        return {16'b0, 8'(sz), 2'b00, rx_active, m_en, m_to, m_ovr,
                (sz == DEPTH), (sz > 0)};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic rx_edge, req, popq, flush, clr_t, clr_o, ovf, to_set, irq_n;
        logic [31:0] nrdt;
        int sz;
        if (!rst_n) begin
            mq.delete();
            m_ovr = 0; m_to = 0; m_en = 0; m_ack = 0; m_irq = 0; m_rxd_q = 0;
            m_rdt = 0; m_idle = 0;
        end else begin
            sz = mq.size();
            irq_n = m_en && (sz >= WM || m_to || m_ovr);
            rx_edge = rx_done && !m_rxd_q;
            m_rxd_q = rx_done;
            req = !m_ack && cyc && stb;
            nrdt = 0; popq = 0; flush = 0; clr_t = 0; clr_o = 0;
            if (req && !we) begin
                if (adr) nrdt = m_stat();
                else if (sz > 0) begin nrdt = {24'b0, mq[0]}; popq = 1; end
            end
            if (req && we && adr) begin
                flush = dat[7]; clr_o = dat[2]; clr_t = dat[3]; m_en = dat[4];
            end
            ovf = 0;
            if (flush) mq.delete();
            else begin
                if (popq) void'(mq.pop_front());
                if (rx_edge) begin
                    if (mq.size() < DEPTH) mq.push_back(rx_data);
                    else ovf = 1;
                end
            end
            // idle clocks since the last FIFO event while data waits on a quiet line
            to_set = 0;
            if (rx_edge || popq || flush) m_idle = 0;
            else if (sz > 0 && !rx_active) begin
                if (m_idle == TO - 1) to_set = 1;
                else m_idle++;
            end
            if (sz == 0 || clr_t) m_to = 0;
            if (to_set) m_to = 1;
            if (clr_o) m_ovr = 0;
            if (ovf) m_ovr = 1;
            m_ack = req; m_rdt = nrdt; m_irq = irq_n;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("ack_model", {31'b0, ack}, {31'b0, m_ack});
        chk("rdt_model", rdt, m_rdt);
        chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
    end

    // ---------------- stimulus helpers (start and end on a negedge) ----------------
    task automatic bus(input logic w, input logic a, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; lat = 0; r = '0;
        do begin @(negedge clk); lat++; end while (!ack && lat < 8);
        if (!ack) begin
            checks++; errors++;
            $display("FAIL bus_ack_timeout: got no ack expected ack within 8 cycles at %0t", $time);
        end
        r = rdt;
        cyc = 0; stb = 0; we = 0; dat = '0;
    endtask

    task automatic rd(input logic a, input logic [31:0] exp, input string name);
        logic [31:0] r; int lat;
        bus(1'b0, a, '0, r, lat);
        chk(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] d);
        logic [31:0] r; int lat;
        bus(1'b1, ADR_STAT, d, r, lat);
    endtask

    task automatic push(input logic [7:0] b);
        rx_done = 1; rx_data = b;
        @(negedge clk);
        rx_done = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r; int lat;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // 1: reset mid-ack with irq high
        wr(32'h10);
        for (int i = 0; i < 4; i++) push(8'(i));
        @(negedge clk);
        chk("t1_irq_before_reset", {31'b0, irq}, 32'd1);
        cyc = 1; stb = 1; we = 0; adr = ADR_DATA;
        @(negedge clk);
        chk("t1_ack_mid", {31'b0, ack}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("t1_ack_async", {31'b0, ack}, 32'd0);
        chk("t1_irq_async", {31'b0, irq}, 32'd0);
        cyc = 0; stb = 0;
        rx_done = 1; rx_data = 8'hEE;
        @(negedge clk);
        rx_done = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        rd(ADR_STAT, 32'h0, "t1_stat_after_reset");

        // 2: two bytes in order
        push(8'hA5); push(8'h3C);
        rd(ADR_DATA, 32'hA5, "t2_data0");
        rd(ADR_DATA, 32'h3C, "t2_data1");
        rd(ADR_STAT, 32'h0, "t2_stat_empty");

        // 3: watermark interrupt timing
        wr(32'h10);
        for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
        rx_done = 1; rx_data = 8'h23;
        @(negedge clk);
        chk("t3_irq_same_cycle", {31'b0, irq}, 32'd0);
        rx_done = 0;
        @(negedge clk);
        chk("t3_irq_rises", {31'b0, irq}, 32'd1);
        rd(ADR_DATA, 32'h20, "t3_pop");
        chk("t3_irq_still", {31'b0, irq}, 32'd1);
        @(negedge clk);
        chk("t3_irq_falls", {31'b0, irq}, 32'd0);
        wr(32'h80);

        // 4: overrun
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        rd(ADR_STAT, 32'h0000_0807, "t4_stat_overrun");
        wr(32'h14);
        rd(ADR_STAT, 32'h0000_0813, "t4_stat_cleared");
        for (int i = 0; i < 8; i++) rd(ADR_DATA, 32'h10 + i, "t4_data");
        rd(ADR_DATA, 32'h0, "t4_empty");
        wr(32'h00);

        // 5: idle timeout, and no timeout while a frame is in progress
        wr(32'h10);
        push(8'h55);
        repeat (TO + 5) @(negedge clk);
        rd(ADR_STAT, 32'h0000_0119, "t5_stat_timeout");
        chk("t5_irq_timeout", {31'b0, irq}, 32'd1);
        wr(32'h98);
        rx_active = 1;
        push(8'h66);
        repeat (TO + 60) @(negedge clk);
        rd(ADR_STAT, 32'h0000_0131, "t5_stat_active");
        chk("t5_irq_active", {31'b0, irq}, 32'd0);
        rx_active = 0;
        wr(32'h80);

        // 6: push and pop together on a full FIFO
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        rx_done = 1; rx_data = 8'h99;
        cyc = 1; stb = 1; we = 0; adr = ADR_DATA;
        @(negedge clk);
        chk("t6_pop_data", rdt, 32'h40);
        rx_done = 0; cyc = 0; stb = 0;
        @(negedge clk);
        rd(ADR_STAT, 32'h0000_0803, "t6_stat_full");
        for (int i = 1; i < 8; i++) rd(ADR_DATA, 32'h40 + i, "t6_data");
        rd(ADR_DATA, 32'h99, "t6_data_last");
        @(negedge clk);
        bus(1'b0, ADR_DATA, '0, r, lat);
        chk("t6_empty_data", r, 32'h0);
        chk("t6_ack_latency", 32'(lat), 32'd1);

        // Random traffic, checked by the per-cycle model comparison
        for (int pass = 0; pass < 2; pass++) begin
            int hold = 0;
            for (int c = 0; c < 3000; c++) begin
                if (hold > 0) hold--;
                else begin
                    rx_done = ($urandom_range(0, 3) == 0);
                    if (rx_done) hold = $urandom_range(0, 2);
                end
                rx_data = 8'($urandom);
                if ($urandom_range(0, 49) == 0) rx_active = ~rx_active;
                cyc = ($urandom_range(0, 2) == 0);
                stb = cyc && ($urandom_range(0, 3) != 0);
                we  = ($urandom_range(0, 3) == 0);
                adr = 1'($urandom);
                dat = $urandom & 32'hFFFF_FF7F;
                if ($urandom_range(0, 15) == 0) dat[7] = 1'b1;
                @(negedge clk);
            end
            rx_done = 0; cyc = 0; stb = 0; rx_active = 0;
            // quiet stretch lets any waiting data time out
            repeat (TO + 20) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
